// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared ISA field constants and multdiv FSM encoding for the hazard and bypass units.
package hazard_stall_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [4:0] REG_STATUS = 5'd30;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_md_sequencer.sv
// Multdiv launch/wait sequencer with timeout and a result register held for DX->XM.
// state   | meaning
// MD_IDLE | no operation; a mul/div in DX launches (start pulse, stall)
// MD_WAIT | operation in flight; pipeline stalled, counter running
// MD_DONE | result latched; one unstalled cycle so the mul/div leaves DX
module md_sequencer
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mul,
    input  logic        start_div,
    input  logic [31:0] md_result_in,
    input  logic        md_rdy,
    input  logic        md_exc,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        busy,
    output logic [31:0] md_result,
    output logic        md_overflow
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       md_result_q, md_result_d;
    logic              md_overflow_q, md_overflow_d;
    logic              launch;

    assign launch = !reset && (state_q == MD_IDLE) && (start_mul || start_div);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        md_result_d   = md_result_q;
        md_overflow_d = md_overflow_q;
        case (state_q)
            MD_IDLE: begin
                if (launch) begin
                    cnt_d   = '0;
                    state_d = MD_WAIT;
                end
            end
            MD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A ready result takes precedence over the timeout in the same cycle
                if (md_rdy) begin
                    md_result_d   = md_result_in;
                    md_overflow_d = md_exc;
                    state_d       = MD_DONE;
                end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                    md_result_d   = '0;
                    md_overflow_d = 1'b1;
                    state_d       = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= MD_IDLE;
            cnt_q         <= '0;
            md_result_q   <= '0;
            md_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            md_result_q   <= md_result_d;
            md_overflow_q <= md_overflow_d;
        end
    end

    assign ctrl_mult   = launch && start_mul;
    assign ctrl_div    = launch && start_div && !start_mul;
    assign stall       = launch || (!reset && state_q == MD_WAIT);
    assign busy        = !reset && (state_q != MD_IDLE);
    assign md_result   = md_result_q;
    assign md_overflow = md_overflow_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch / multdiv hazard resolution driving the PC, FD, DX and XM latch controls.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_out_ir,
    input  logic [31:0] dx_out_ir,
    input  logic        x_branch_taken,
    input  logic [31:0] md_result_in,
    input  logic        md_rdy,
    input  logic        md_exc,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        fd_flush,
    output logic        dx_insert_nop,
    output logic        xm_insert_nop,
    output logic [31:0] md_result,
    output logic        md_overflow,
    output logic        md_busy
);

    logic [4:0] fd_op, fd_rs1, fd_rs2;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic       dx_is_mul, dx_is_div;
    logic       load_use, md_stall;
    logic       unused_ir_bits;

    assign fd_op  = fd_out_ir[31:27];
    assign fd_rs1 = fd_out_ir[21:17];
    assign dx_op  = dx_out_ir[31:27];
    assign dx_rd  = dx_out_ir[26:22];
    assign dx_alu = dx_out_ir[6:2];

    assign unused_ir_bits = ^{fd_out_ir[11:0], dx_out_ir[21:7], dx_out_ir[1:0]};

    always_comb begin
        fd_rs2 = 5'd0;
        case (fd_op)
            OP_RTYPE:                     fd_rs2 = fd_out_ir[16:12];
            OP_BEX:                       fd_rs2 = REG_STATUS;
            OP_SW, OP_BNE, OP_BLT, OP_JR: fd_rs2 = fd_out_ir[26:22];
            OP_J, OP_JAL, OP_SETX:        fd_rs2 = 5'd0;
            default:                      fd_rs2 = 5'd0;
        endcase
    end

    assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
    assign dx_is_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);

    // Store data of a sw comes through the WM bypass, so only its base register stalls
    assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                      ((fd_rs1 == dx_rd) || ((fd_rs2 == dx_rd) && (fd_op != OP_SW)));

    md_sequencer #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clock        (clock),
        .reset        (reset),
        .start_mul    (dx_is_mul),
        .start_div    (dx_is_div),
        .md_result_in (md_result_in),
        .md_rdy       (md_rdy),
        .md_exc       (md_exc),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .stall        (md_stall),
        .busy         (md_busy),
        .md_result    (md_result),
        .md_overflow  (md_overflow)
    );

    always_comb begin
        pc_we         = 1'b1;
        fd_we         = 1'b1;
        dx_we         = 1'b1;
        fd_flush      = 1'b0;
        dx_insert_nop = 1'b0;
        xm_insert_nop = 1'b0;
        if (!reset) begin
            if (md_stall) begin
                pc_we         = 1'b0;
                fd_we         = 1'b0;
                dx_we         = 1'b0;
                xm_insert_nop = 1'b1;
            end else if (x_branch_taken) begin
                fd_flush      = 1'b1;
                dx_insert_nop = 1'b1;
                pc_we         = 1'b1;
            end else if (load_use) begin
                pc_we         = 1'b0;
                fd_we         = 1'b0;
                dx_insert_nop = 1'b1;
            end
        end
    end

endmodule
